// File: rtl/padring_cfg_pkg.sv
// padring_cfg_pkg: side encodings, FSM states and width helpers shared by padring_cfg_ctrl and its bench
package padring_cfg_pkg;
  typedef enum logic [1:0] {SIDE_NO, SIDE_EA, SIDE_SO, SIDE_WE} side_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SETTLE, S_DONE} state_e;
  function automatic int ptr_w(input int ngpio);
    return $clog2(4 * ngpio);
  endfunction
  function automatic int cnt_w(input int settle);
    return settle < 2 ? 1 : $clog2(settle);
  endfunction
endpackage

// File: rtl/padring_cfg_ctrl_if.sv
// padring_cfg_ctrl_if: shadow write port (req_*) plus commit/busy/done/err/err_clr between requester (master) and controller (slave)
interface padring_cfg_ctrl_if #(
  parameter int CFGW  = 8,
  parameter int TECHW = 18
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_side;
  logic [3:0]       req_pad;
  logic [CFGW-1:0]  req_cfg;
  logic [TECHW-1:0] req_tech;
  logic             commit;
  logic             busy;
  logic             done;
  logic             err;
  logic             err_clr;
  modport master (
    output req_valid, req_side, req_pad, req_cfg, req_tech, commit, err_clr,
    input  req_ready, busy, done, err
  );
  modport slave (
    input  req_valid, req_side, req_pad, req_cfg, req_tech, commit, err_clr,
    output req_ready, busy, done, err
  );
endinterface

// File: rtl/padring_cfg_bank.sv
// padring_cfg_bank: one padring side; wr_* loads shadow+dirty, ap_* copies shadow to packed live_cfg/live_tech and clears dirty
module padring_cfg_bank #(
  parameter int               NGPIO      = 9,
  parameter int               CFGW       = 8,
  parameter int               TECHW      = 18,
  parameter logic [CFGW-1:0]  RESET_CFG  = '0,
  parameter logic [TECHW-1:0] RESET_TECH = '0
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   wr_en,
  input  logic [3:0]             wr_pad,
  input  logic [CFGW-1:0]        wr_cfg,
  input  logic [TECHW-1:0]       wr_tech,
  input  logic                   ap_en,
  input  logic [3:0]             ap_pad,
  output logic [NGPIO-1:0]       dirty,
  output logic [NGPIO*CFGW-1:0]  live_cfg,
  output logic [NGPIO*TECHW-1:0] live_tech
);
  logic [CFGW-1:0]  sh_cfg  [NGPIO];
  logic [TECHW-1:0] sh_tech [NGPIO];
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      dirty     <= '0;
      live_cfg  <= {NGPIO{RESET_CFG}};
      live_tech <= {NGPIO{RESET_TECH}};
      for (int p = 0; p < NGPIO; p++) begin
        sh_cfg[p]  <= RESET_CFG;
        sh_tech[p] <= RESET_TECH;
      end
    end else begin
      for (int p = 0; p < NGPIO; p++) begin
        if (wr_en && int'(wr_pad) == p) begin
          sh_cfg[p]  <= wr_cfg;
          sh_tech[p] <= wr_tech;
          dirty[p]   <= 1'b1;
        end
        if (ap_en && int'(ap_pad) == p) begin
          live_cfg[p*CFGW +: CFGW]    <= sh_cfg[p];
          live_tech[p*TECHW +: TECHW] <= sh_tech[p];
          dirty[p]                    <= 1'b0;
        end
      end
    end
endmodule

// File: rtl/padring_cfg_ctrl.sv
// padring_cfg_ctrl: sequenced padring config; bus=write port+commit/busy/done/err, *_cfg/*_tech_cfg=live per-side words, one pad applied per slot then SETTLE idle cycles
module padring_cfg_ctrl
  import padring_cfg_pkg::*;
#(
  parameter int               NGPIO      = 9,
  parameter int               CFGW       = 8,
  parameter int               TECHW      = 18,
  parameter int               SETTLE     = 4,
  parameter logic [CFGW-1:0]  RESET_CFG  = '0,
  parameter logic [TECHW-1:0] RESET_TECH = '0
) (
  input  logic                   clk,
  input  logic                   nreset,
  padring_cfg_ctrl_if.slave      bus,
  output logic [NGPIO*CFGW-1:0]  no_cfg,
  output logic [NGPIO*CFGW-1:0]  ea_cfg,
  output logic [NGPIO*CFGW-1:0]  so_cfg,
  output logic [NGPIO*CFGW-1:0]  we_cfg,
  output logic [NGPIO*TECHW-1:0] no_tech_cfg,
  output logic [NGPIO*TECHW-1:0] ea_tech_cfg,
  output logic [NGPIO*TECHW-1:0] so_tech_cfg,
  output logic [NGPIO*TECHW-1:0] we_tech_cfg
);
  localparam int NSLOT = 4 * NGPIO;
  localparam int PW    = ptr_w(NGPIO);
  localparam int CW    = cnt_w(SETTLE);
  state_e                 state, state_n;
  logic [PW-1:0]          ptr, ptr_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [NSLOT-1:0]       dirty;
  logic [NGPIO*CFGW-1:0]  cfg_q  [4];
  logic [NGPIO*TECHW-1:0] tech_q [4];
  logic                   wr_ok, bad_wr, ap_en, last, err_q;
  logic [1:0]             ap_side;
  logic [3:0]             ap_pad;
  assign bus.req_ready = state == S_IDLE;
  assign bus.busy      = state != S_IDLE;
  assign bus.done      = state == S_DONE;
  assign bus.err       = err_q;
  assign wr_ok   = bus.req_valid && bus.req_ready && int'(bus.req_pad) < NGPIO;
  assign bad_wr  = bus.req_valid && bus.req_ready && int'(bus.req_pad) >= NGPIO;
  assign ap_side = 2'(int'(ptr) / NGPIO);
  assign ap_pad  = 4'(int'(ptr) % NGPIO);
  assign last    = int'(ptr) == NSLOT - 1;
  for (genvar i = 0; i < 4; i++) begin : g_bank
    padring_cfg_bank #(
      .NGPIO(NGPIO), .CFGW(CFGW), .TECHW(TECHW), .RESET_CFG(RESET_CFG), .RESET_TECH(RESET_TECH)
    ) u_bank (
      .clk      (clk),
      .nreset   (nreset),
      .wr_en    (wr_ok && bus.req_side == 2'(i)),
      .wr_pad   (bus.req_pad),
      .wr_cfg   (bus.req_cfg),
      .wr_tech  (bus.req_tech),
      .ap_en    (ap_en && ap_side == 2'(i)),
      .ap_pad   (ap_pad),
      .dirty    (dirty[i*NGPIO +: NGPIO]),
      .live_cfg (cfg_q[i]),
      .live_tech(tech_q[i])
    );
  end
  assign no_cfg      = cfg_q[SIDE_NO];
  assign ea_cfg      = cfg_q[SIDE_EA];
  assign so_cfg      = cfg_q[SIDE_SO];
  assign we_cfg      = cfg_q[SIDE_WE];
  assign no_tech_cfg = tech_q[SIDE_NO];
  assign ea_tech_cfg = tech_q[SIDE_EA];
  assign so_tech_cfg = tech_q[SIDE_SO];
  assign we_tech_cfg = tech_q[SIDE_WE];
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      err_q <= bad_wr ? 1'b1 : bus.err_clr ? 1'b0 : err_q;
    end
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    ap_en   = 1'b0;
    case (state)
      S_IDLE: if (bus.commit) begin
        state_n = S_SCAN;
        ptr_n   = '0;
      end
      S_SCAN: begin
        ap_en = dirty[ptr];
        if (dirty[ptr] && SETTLE > 0) begin
          state_n = S_SETTLE;
          cnt_n   = CW'(SETTLE - 1);
        end else begin
          state_n = last ? S_DONE : S_SCAN;
          ptr_n   = ptr + 1'b1;
        end
      end
      S_SETTLE: if (cnt == '0) begin
        state_n = last ? S_DONE : S_SCAN;
        ptr_n   = ptr + 1'b1;
      end else cnt_n = cnt - 1'b1;
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_padring_cfg_ctrl.sv
// tb_padring_cfg_ctrl: randomized self-checking bench for padring_cfg_ctrl against a slot-level schedule model
module tb_padring_cfg_ctrl;
  localparam int NGPIO = 9, CFGW = 8, TECHW = 18, SETTLE = 4, NSLOT = 4 * NGPIO;
  logic clk = 1'b0, nreset = 1'b0;
  logic [NGPIO*CFGW-1:0]  no_cfg, ea_cfg, so_cfg, we_cfg;
  logic [NGPIO*TECHW-1:0] no_tech_cfg, ea_tech_cfg, so_tech_cfg, we_tech_cfg;
  padring_cfg_ctrl_if #(.CFGW(CFGW), .TECHW(TECHW)) bus ();
  padring_cfg_ctrl #(
    .NGPIO(NGPIO), .CFGW(CFGW), .TECHW(TECHW), .SETTLE(SETTLE), .RESET_CFG('0), .RESET_TECH('0)
  ) dut (
    .clk(clk), .nreset(nreset), .bus(bus),
    .no_cfg(no_cfg), .ea_cfg(ea_cfg), .so_cfg(so_cfg), .we_cfg(we_cfg),
    .no_tech_cfg(no_tech_cfg), .ea_tech_cfg(ea_tech_cfg), .so_tech_cfg(so_tech_cfg), .we_tech_cfg(we_tech_cfg)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic [CFGW-1:0]  sh_c [NSLOT], live_c [NSLOT];
  logic [TECHW-1:0] sh_t [NSLOT], live_t [NSLOT];
  bit dirty_m [NSLOT];
  bit err_m;
  function automatic void model_reset();
    for (int s = 0; s < NSLOT; s++) begin
      sh_c[s] = '0; live_c[s] = '0; sh_t[s] = '0; live_t[s] = '0; dirty_m[s] = 0;
    end
    err_m = 0;
  endfunction
  function automatic logic [NSLOT*CFGW-1:0] exp_cfg();
    logic [NSLOT*CFGW-1:0] r;
    for (int s = 0; s < NSLOT; s++) r[s*CFGW +: CFGW] = live_c[s];
    return r;
  endfunction
  function automatic logic [NSLOT*TECHW-1:0] exp_tech();
    logic [NSLOT*TECHW-1:0] r;
    for (int s = 0; s < NSLOT; s++) r[s*TECHW +: TECHW] = live_t[s];
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input int side, input int pad, input logic [CFGW-1:0] c, input logic [TECHW-1:0] t);
    n_vec++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL write_ready: got %b expected 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_side = 2'(side); bus.req_pad = 4'(pad); bus.req_cfg = c; bus.req_tech = t;
    tick();
    bus.req_valid = 1'b0;
    if (pad < NGPIO) begin
      sh_c[side*NGPIO+pad] = c; sh_t[side*NGPIO+pad] = t; dirty_m[side*NGPIO+pad] = 1;
    end else err_m = 1;
    n_vec++;
    if (bus.err !== err_m) begin
      n_err++;
      $display("FAIL write_err side=%0d pad=%0d: got %b expected %b", side, pad, bus.err, err_m);
    end
  endtask
  task automatic apply_and_check(input string tag, input bit inject, output int done_seen);
    int apply_at [NSLOT];
    int c = 1, done_at, inj_side, inj_pad;
    logic [CFGW-1:0] inj_c;
    logic [TECHW-1:0] inj_t;
    for (int s = 0; s < NSLOT; s++) begin
      apply_at[s] = 0;
      if (dirty_m[s]) begin
        apply_at[s] = c + 1;
        c += 1 + SETTLE;
      end else c++;
    end
    done_at = c;
    inj_side = $urandom_range(0, 3); inj_pad = $urandom_range(0, NGPIO - 1);
    inj_c = CFGW'($urandom); inj_t = TECHW'($urandom);
    done_seen = -1;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    for (int j = 1; j <= done_at + 1; j++) begin
      for (int s = 0; s < NSLOT; s++)
        if (apply_at[s] == j) begin
          live_c[s] = sh_c[s]; live_t[s] = sh_t[s]; dirty_m[s] = 0;
        end
      n_vec += 5;
      if ({we_cfg, so_cfg, ea_cfg, no_cfg} !== exp_cfg()) begin
        n_err++;
        $display("FAIL %s cfg cycle %0d: got %h expected %h", tag, j, {we_cfg, so_cfg, ea_cfg, no_cfg}, exp_cfg());
      end
      if ({we_tech_cfg, so_tech_cfg, ea_tech_cfg, no_tech_cfg} !== exp_tech()) begin
        n_err++;
        $display("FAIL %s tech cycle %0d: got %h expected %h", tag, j,
                 {we_tech_cfg, so_tech_cfg, ea_tech_cfg, no_tech_cfg}, exp_tech());
      end
      if (bus.busy !== (j <= done_at)) begin
        n_err++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", tag, j, bus.busy, j <= done_at);
      end
      if (bus.done !== (j == done_at)) begin
        n_err++;
        $display("FAIL %s done cycle %0d: got %b expected %b", tag, j, bus.done, j == done_at);
      end
      if (bus.req_ready !== (j > done_at)) begin
        n_err++;
        $display("FAIL %s ready cycle %0d: got %b expected %b", tag, j, bus.req_ready, j > done_at);
      end
      if (bus.done === 1'b1 && done_seen < 0) done_seen = j;
      if (inject && j == 3) begin
        bus.req_valid = 1'b1; bus.req_side = 2'(inj_side); bus.req_pad = 4'(inj_pad);
        bus.req_cfg = inj_c; bus.req_tech = inj_t;
      end
      if (inject && j == 10) bus.commit = 1'b1;
      if (inject && j == 11) bus.commit = 1'b0;
      if (j <= done_at) tick();
    end
    if (inject) begin
      tick();
      bus.req_valid = 1'b0;
      sh_c[inj_side*NGPIO+inj_pad] = inj_c; sh_t[inj_side*NGPIO+inj_pad] = inj_t;
      dirty_m[inj_side*NGPIO+inj_pad] = 1;
    end
  endtask
  task automatic test_reset();
    n_vec += 6;
    if ({we_cfg, so_cfg, ea_cfg, no_cfg} !== exp_cfg()) begin
      n_err++; $display("FAIL reset_cfg: got %h expected %h", {we_cfg, so_cfg, ea_cfg, no_cfg}, exp_cfg());
    end
    if ({we_tech_cfg, so_tech_cfg, ea_tech_cfg, no_tech_cfg} !== exp_tech()) begin
      n_err++; $display("FAIL reset_tech: got %h expected %h", {we_tech_cfg, so_tech_cfg, ea_tech_cfg, no_tech_cfg}, exp_tech());
    end
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", bus.err); end
  endtask
  task automatic test_single_pad();
    int ds;
    do_write(1, 3, 8'hA5, 18'h2AAAA);
    apply_and_check("single_pad", 0, ds);
    n_vec += 3;
    if (ds != 41) begin n_err++; $display("FAIL single_pad_done_cycle: got %0d expected 41", ds); end
    if (ea_cfg[31:24] !== 8'hA5) begin n_err++; $display("FAIL single_pad_ea_cfg: got %h expected a5", ea_cfg[31:24]); end
    if (ea_tech_cfg[71:54] !== 18'h2AAAA) begin
      n_err++; $display("FAIL single_pad_ea_tech: got %h expected 2aaaa", ea_tech_cfg[71:54]);
    end
  endtask
  task automatic test_empty_commit();
    int ds;
    apply_and_check("empty_commit", 0, ds);
    n_vec++;
    if (ds != 37) begin n_err++; $display("FAIL empty_commit_done_cycle: got %0d expected 37", ds); end
  endtask
  task automatic test_back_to_back();
    int ds;
    do_write(0, 0, 8'h11, 18'h00111);
    do_write(0, 0, 8'h22, 18'h00222);
    apply_and_check("back_to_back", 1, ds);
    n_vec++;
    if (no_cfg[7:0] !== 8'h22) begin n_err++; $display("FAIL last_write_wins: got %h expected 22", no_cfg[7:0]); end
    for (int i = 0; i < 4; i++) begin
      n_vec += 2;
      if (bus.done !== 1'b0) begin n_err++; $display("FAIL queued_commit_done: got %b expected 0", bus.done); end
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL queued_commit_busy: got %b expected 0", bus.busy); end
      tick();
    end
    apply_and_check("held_write_flush", 0, ds);
  endtask
  task automatic test_bad_pad();
    int ds;
    do_write(1, 9, 8'hFF, 18'h3FFFF);
    apply_and_check("bad_pad_commit", 0, ds);
    n_vec++;
    if (ds != 37) begin n_err++; $display("FAIL bad_pad_done_cycle: got %0d expected 37", ds); end
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0; err_m = 0;
    n_vec++;
    if (bus.err !== 1'b0) begin n_err++; $display("FAIL err_clr: got %b expected 0", bus.err); end
    bus.err_clr = 1'b1;
    do_write(2, 12, 8'h5A, 18'h12345);
    bus.err_clr = 1'b0;
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0; err_m = 0;
    n_vec++;
    if (bus.err !== 1'b0) begin n_err++; $display("FAIL err_clr_again: got %b expected 0", bus.err); end
  endtask
  task automatic test_mid_apply_reset();
    int f = -1, ds;
    for (int side = 0; side < 4; side++)
      do_write(side, $urandom_range(0, NGPIO - 1), CFGW'($urandom) | 8'h01, TECHW'($urandom));
    for (int s = NSLOT - 1; s >= 0; s--) if (dirty_m[s]) f = s;
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    for (int j = 1; j < f + 3; j++) tick();
    live_c[f] = sh_c[f]; live_t[f] = sh_t[f]; dirty_m[f] = 0;
    n_vec += 2;
    if ({we_cfg, so_cfg, ea_cfg, no_cfg} !== exp_cfg()) begin
      n_err++; $display("FAIL pre_reset_cfg: got %h expected %h", {we_cfg, so_cfg, ea_cfg, no_cfg}, exp_cfg());
    end
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy: got %b expected 1", bus.busy); end
    #2 nreset = 1'b0;
    #1;
    model_reset();
    test_reset();
    @(negedge clk);
    nreset = 1'b1;
    tick();
    apply_and_check("post_reset", 0, ds);
    n_vec++;
    if (ds != 37) begin n_err++; $display("FAIL post_reset_done_cycle: got %0d expected 37", ds); end
  endtask
  task automatic test_random();
    int ds;
    for (int r = 0; r < 6; r++) begin
      for (int w = $urandom_range(1, 8); w > 0; w--)
        do_write($urandom_range(0, 3), $urandom_range(0, NGPIO), CFGW'($urandom), TECHW'($urandom));
      apply_and_check("random", 0, ds);
      bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0; err_m = 0;
      n_vec++;
      if (bus.err !== 1'b0) begin n_err++; $display("FAIL random_err_clr: got %b expected 0", bus.err); end
    end
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_side = '0; bus.req_pad = '0; bus.req_cfg = '0; bus.req_tech = '0;
    bus.commit = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    tick();
    test_reset();
    test_single_pad();
    test_empty_commit();
    test_back_to_back();
    test_bad_pad();
    test_mid_apply_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
